// File: rtl/decision_axil_regbank.sv
`default_nettype none
// ============================================================================
// Module   : decision_axil_regbank
// Purpose  : AXI4-Lite slave register bank with a per-channel threshold
//            decision engine. Software programs channel enables and
//            thresholds; each enabled channel's sensor word is compared
//            against its threshold every cycle, producing registered
//            alarms, sticky status bits and a level interrupt.
//
// Ports    :
//   ACLK, ARESET          clock / asynchronous active-high reset
//   S_AXI_AW*             write address channel (AWPROT ignored)
//   S_AXI_W*              write data channel with byte strobes
//   S_AXI_B*              write response (SLVERR on writes to STATUS)
//   S_AXI_AR*             read address channel (ARPROT ignored)
//   S_AXI_R*              read data channel
//   sensor_in             packed per-channel unsigned sensor words
//   alarm                 registered per-channel live decision
//   irq                   level interrupt = irq_en & |sticky
//
// Register map (word index):
//   0      CTRL   [C_NUM_CH-1:0] enables, [W-1] irq_en, [W-2] CLR (W1, reads 0)
//   1      STATUS sticky alarm bits (read-only)
//   2..N+1 THR[k] per-channel threshold
//   rest   scratch
//
// Revision : 1.0  initial release
// ============================================================================
module decision_axil_regbank #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_NUM_REGS   = 8,
    parameter int C_NUM_CH     = 4,
    parameter int C_ADDR_WIDTH = 5
) (
    input  logic                              ACLK,
    input  logic                              ARESET,

    input  logic [C_ADDR_WIDTH-1:0]           S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,

    input  logic [C_DATA_WIDTH-1:0]           S_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0]         S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,

    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,

    input  logic [C_ADDR_WIDTH-1:0]           S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,

    output logic [C_DATA_WIDTH-1:0]           S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,

    input  logic [C_NUM_CH*C_DATA_WIDTH-1:0]  sensor_in,
    output logic [C_NUM_CH-1:0]               alarm,
    output logic                              irq
);

    localparam int c_STRB_W   = C_DATA_WIDTH / 8;
    localparam int c_ADDR_LSB = $clog2(c_STRB_W);
    localparam int c_IDX_W    = $clog2(C_NUM_REGS);

    localparam logic [c_IDX_W-1:0] c_IDX_CTRL   = c_IDX_W'(0);
    localparam logic [c_IDX_W-1:0] c_IDX_STATUS = c_IDX_W'(1);

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    localparam int c_BIT_IRQ_EN = C_DATA_WIDTH - 1;
    localparam int c_BIT_CLR    = C_DATA_WIDTH - 2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [C_DATA_WIDTH-1:0]  r_regs [C_NUM_REGS];
    logic [C_NUM_CH-1:0]      r_sticky;
    logic [C_NUM_CH-1:0]      r_alarm;

    // Goes high on the first edge after reset so the READY outputs stay low
    // while reset is asserted and during the reset-release cycle.
    logic                     r_live;

    logic                     r_aw_held;
    logic [c_IDX_W-1:0]       r_aw_idx;
    logic                     r_w_held;
    logic [C_DATA_WIDTH-1:0]  r_w_data;
    logic [c_STRB_W-1:0]      r_w_strb;

    logic                     r_bvalid;
    logic [1:0]               r_bresp;

    logic                     r_rvalid;
    logic [1:0]               r_rresp;
    logic [C_DATA_WIDTH-1:0]  r_rdata;

    // ------------------------------------------------------------------------
    // Write channel handshakes and commit
    // ------------------------------------------------------------------------
    logic                     w_awready;
    logic                     w_wready;
    logic                     w_aw_hs;
    logic                     w_w_hs;
    logic                     w_commit;
    logic [c_IDX_W-1:0]       w_widx;
    logic [C_DATA_WIDTH-1:0]  w_wdata;
    logic [c_STRB_W-1:0]      w_wstrb;
    logic                     w_wr_status;
    logic                     w_clr_pulse;

    assign w_awready = r_live & ~r_aw_held & ~r_bvalid;
    assign w_wready  = r_live & ~r_w_held  & ~r_bvalid;
    assign w_aw_hs   = S_AXI_AWVALID & w_awready;
    assign w_w_hs    = S_AXI_WVALID  & w_wready;

    // A write commits once both halves are present, whether they arrived
    // earlier into the holding registers or are handshaking this cycle.
    assign w_commit  = ~r_bvalid & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

    assign w_widx    = r_aw_held ? r_aw_idx : S_AXI_AWADDR[C_ADDR_WIDTH-1:c_ADDR_LSB];
    assign w_wdata   = r_w_held  ? r_w_data : S_AXI_WDATA;
    assign w_wstrb   = r_w_held  ? r_w_strb : S_AXI_WSTRB;

    assign w_wr_status = (w_widx == c_IDX_STATUS);

    // CLR lives in the top byte, so it only fires when that byte is strobed.
    assign w_clr_pulse = w_commit & (w_widx == c_IDX_CTRL)
                       & w_wstrb[c_STRB_W-1] & w_wdata[c_BIT_CLR];

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
        end else if (w_commit) begin
            // Holding registers are released at commit; READY stays low
            // anyway until the B handshake because BVALID gates it.
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= S_AXI_AWADDR[C_ADDR_WIDTH-1:c_ADDR_LSB];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_w_data <= S_AXI_WDATA;
                r_w_strb <= S_AXI_WSTRB;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_bvalid <= 1'b0;
            r_bresp  <= c_RESP_OKAY;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_status ? c_RESP_SLVERR : c_RESP_OKAY;
        end else if (r_bvalid && S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Register file (STATUS slot is never written; it is sourced from sticky)
    // ------------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit && !w_wr_status) begin
            for (int b = 0; b < c_STRB_W; b++) begin
                if (w_wstrb[b]) begin
                    r_regs[w_widx][b*8 +: 8] <= w_wdata[b*8 +: 8];
                end
            end
            // CLR is a pulse, never stored, so it always reads back 0.
            if (w_widx == c_IDX_CTRL) begin
                r_regs[c_IDX_CTRL][c_BIT_CLR] <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------------
    logic                     w_arready;
    logic                     w_ar_hs;
    logic [c_IDX_W-1:0]       w_ridx;
    logic [C_DATA_WIDTH-1:0]  w_rd_word;

    assign w_arready = r_live & ~r_rvalid;
    assign w_ar_hs   = S_AXI_ARVALID & w_arready;
    assign w_ridx    = S_AXI_ARADDR[C_ADDR_WIDTH-1:c_ADDR_LSB];
    assign w_rd_word = (w_ridx == c_IDX_STATUS) ? C_DATA_WIDTH'(r_sticky)
                                                : r_regs[w_ridx];

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rvalid <= 1'b0;
            r_rresp  <= c_RESP_OKAY;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rresp  <= c_RESP_OKAY;
            r_rdata  <= w_rd_word;
        end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Decision engine
    // ------------------------------------------------------------------------
    logic [C_NUM_CH-1:0] w_hit;

    generate
        for (genvar k = 0; k < C_NUM_CH; k++) begin : g_ch
            assign w_hit[k] = r_regs[c_IDX_CTRL][k]
                            & (sensor_in[k*C_DATA_WIDTH +: C_DATA_WIDTH] > r_regs[k+2]);
        end
    endgenerate

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_alarm  <= '0;
            r_sticky <= '0;
        end else begin
            r_alarm  <= w_hit;
            // A new hit wins over a simultaneous clear.
            r_sticky <= w_hit | (r_sticky & ~{C_NUM_CH{w_clr_pulse}});
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;

    assign alarm = r_alarm;
    // AND of two register outputs: no combinational input path, so no glitch.
    assign irq   = r_regs[c_IDX_CTRL][c_BIT_IRQ_EN] & (|r_sticky);

    logic w_unused;
    assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[c_ADDR_LSB-1:0], S_AXI_ARADDR[c_ADDR_LSB-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_decision_axil_regbank.sv
`default_nettype none
// ============================================================================
// Module   : tb_decision_axil_regbank
// Purpose  : Self-checking bench for decision_axil_regbank (32-bit, 8 regs,
//            4 channels). Directed scenarios followed by randomized AXI
//            traffic and sensor values, checked against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_decision_axil_regbank;

    localparam int c_W   = 32;
    localparam int c_NR  = 8;
    localparam int c_NCH = 4;
    localparam int c_AW  = 5;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [c_AW-1:0]        awaddr = '0;
    logic [2:0]             awprot = '0;
    logic                   awvalid = 1'b0;
    logic                   awready;
    logic [c_W-1:0]         wdata = '0;
    logic [c_W/8-1:0]       wstrb = '0;
    logic                   wvalid = 1'b0;
    logic                   wready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready = 1'b0;
    logic [c_AW-1:0]        araddr = '0;
    logic [2:0]             arprot = '0;
    logic                   arvalid = 1'b0;
    logic                   arready;
    logic [c_W-1:0]         rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready = 1'b0;
    logic [c_NCH*c_W-1:0]   sensor_in = '0;
    logic [c_NCH-1:0]       alarm;
    logic                   irq;

    always #5 clk = ~clk;

    decision_axil_regbank #(
        .C_DATA_WIDTH (c_W),
        .C_NUM_REGS   (c_NR),
        .C_NUM_CH     (c_NCH),
        .C_ADDR_WIDTH (c_AW)
    ) dut (
        .ACLK          (clk),
        .ARESET        (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .sensor_in     (sensor_in),
        .alarm         (alarm),
        .irq           (irq)
    );

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    logic [c_W-1:0]   m_regs [c_NR];
    logic [c_NCH-1:0] m_sticky = '0;
    logic [c_NCH-1:0] m_alarm  = '0;
    logic [c_NCH-1:0] mon_hit;
    bit               mon_clr;

    // Write announced by the driver, applied by the model on the commit edge.
    int               pend_seq = 0;
    int               done_seq = 0;
    int               pend_idx = 0;
    logic [c_W-1:0]   pend_data = '0;
    logic [3:0]       pend_strb = '0;

    function automatic logic [c_W-1:0] m_read(input int idx);
        if (idx == 1) return c_W'(m_sticky);
        return m_regs[idx];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_NR; i++) m_regs[i] = '0;
            m_sticky = '0;
            m_alarm  = '0;
            done_seq = pend_seq;
        end else begin
            mon_clr = (pend_seq != done_seq) && (pend_idx == 0)
                      && pend_strb[3] && pend_data[30];
            for (int k = 0; k < c_NCH; k++)
                mon_hit[k] = m_regs[0][k] && (sensor_in[k*c_W +: c_W] > m_regs[2+k]);
            m_alarm  = mon_hit;
            m_sticky = mon_hit | (mon_clr ? '0 : m_sticky);
            if (pend_seq != done_seq) begin
                if (pend_idx != 1) begin
                    for (int b = 0; b < 4; b++)
                        if (pend_strb[b]) m_regs[pend_idx][b*8 +: 8] = pend_data[b*8 +: 8];
                    if (pend_idx == 0) m_regs[0][30] = 1'b0;
                end
                done_seq = pend_seq;
            end
        end
    end

    // Every cycle: live outputs against the model, and the one-outstanding
    // rules on the READY signals.
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("alarm", alarm, m_alarm);
            check_eq("irq", irq, m_regs[0][31] & (|m_sticky));
            if (bvalid) check_eq("aw_w_blocked_during_b", {awready, wready}, 2'b00);
            if (rvalid) check_eq("ar_blocked_during_r", arready, 1'b0);
        end
    end

    // Sensor driver: changes on the falling edge.
    bit                   sens_rand = 1'b0;
    logic [c_NCH*c_W-1:0] sens_dir  = '0;

    always @(negedge clk) begin
        if (sens_rand) begin
            for (int k = 0; k < c_NCH; k++)
                sensor_in[k*c_W +: c_W] = c_W'($urandom_range(0, 600));
        end else begin
            sensor_in = sens_dir;
        end
    end

    // ------------------------------------------------------------------------
    // Bus tasks (enter and leave 1 time unit after a rising edge)
    // ------------------------------------------------------------------------
    task automatic axi_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                             input int lead, input int bdel, output logic [1:0] resp);
        int aw_at, w_at, n;
        bit aw_done, w_done, hs_aw, hs_w;
        aw_at = (lead > 0) ? lead : 0;
        w_at  = (lead < 0) ? -lead : 0;
        awaddr  = c_AW'(idx * 4 + int'($urandom_range(0, 3)));
        wdata   = data;
        wstrb   = strb;
        awvalid = (aw_at == 0);
        wvalid  = (w_at == 0);
        aw_done = 1'b0;
        w_done  = 1'b0;
        n       = 0;
        resp    = 2'b11;
        while (!(aw_done && w_done) && n < 50) begin
            @(negedge clk);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            if ((aw_done || hs_aw) && (w_done || hs_w)) begin
                pend_idx  = idx;
                pend_data = data;
                pend_strb = strb;
                pend_seq++;
            end
            @(posedge clk); #1;
            n++;
            if (hs_aw) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (hs_w)  begin wvalid  = 1'b0; w_done  = 1'b1; end
            if (!aw_done && n >= aw_at) awvalid = 1'b1;
            if (!w_done  && n >= w_at)  wvalid  = 1'b1;
        end
        check_eq("wr_handshake_done", aw_done && w_done, 1'b1);
        if (!(aw_done && w_done)) begin
            awvalid = 1'b0;
            wvalid  = 1'b0;
            return;
        end
        check_eq("bvalid_latency", bvalid, 1'b1);
        repeat (bdel) begin
            @(negedge clk);
            check_eq("bvalid_hold", bvalid, 1'b1);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(negedge clk);
        resp = bresp;
        check_eq($sformatf("bresp_w%0d", idx), bresp, (idx == 1) ? 2'b10 : 2'b00);
        @(posedge clk); #1;
        bready = 1'b0;
        check_eq("b_single_response", bvalid, 1'b0);
    endtask

    task automatic axi_read(input int idx, output logic [31:0] d);
        logic [31:0] e;
        bit hs;
        int n;
        araddr  = c_AW'(idx * 4 + int'($urandom_range(0, 3)));
        arvalid = 1'b1;
        hs = 1'b0;
        n  = 0;
        e  = '0;
        d  = '0;
        while (!hs && n < 50) begin
            @(negedge clk);
            if (arready) begin hs = 1'b1; e = m_read(idx); end
            @(posedge clk); #1;
            n++;
        end
        arvalid = 1'b0;
        check_eq("rd_handshake_done", hs, 1'b1);
        if (!hs) return;
        check_eq("rvalid_latency", rvalid, 1'b1);
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            check_eq("rdata_stable", rdata, e);
        end
        rready = 1'b1;
        @(negedge clk);
        d = rdata;
        check_eq($sformatf("rdata_w%0d", idx), rdata, e);
        check_eq("rresp_okay", rresp, 2'b00);
        @(posedge clk); #1;
        rready = 1'b0;
        check_eq("rvalid_clear", rvalid, 1'b0);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    logic [31:0] rd;
    logic [1:0]  br;
    int          r_idx;
    logic [31:0] r_data;

    initial begin
        // Reset state
        @(negedge clk);
        check_eq("rst_outputs",
                 {bvalid, rvalid, bresp, rresp, alarm, irq, awready, wready, arready},
                 '0);
        check_eq("rst_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("ready_low_before_edge", {awready, wready, arready}, 3'b000);
        @(posedge clk); #1;
        check_eq("ready_high_after_edge", {awready, wready, arready}, 3'b111);

        // Readback of words 2..7
        for (int i = 2; i < 8; i++) axi_write(i, 32'h11 * (i - 1), 4'hF, 0, 0, br);
        for (int i = 2; i < 8; i++) begin
            axi_read(i, rd);
            check_eq($sformatf("readback_w%0d", i), rd, 32'h11 * (i - 1));
        end

        // Byte strobes
        axi_write(3, 32'h100, 4'hF, 0, 0, br);
        axi_write(7, 32'hAABBCCDD, 4'hF, 0, 0, br);
        axi_write(7, 32'h0000AB00, 4'b0010, 0, 0, br);
        axi_read(7, rd);
        check_eq("wstrb_merge", rd, 32'hAABBABDD);

        // Single-cycle threshold crossing on channel 1
        axi_write(0, 32'h8000_0002, 4'hF, 0, 0, br);
        sens_dir[1*c_W +: c_W] = 32'h101;
        @(posedge clk); #1;
        check_eq("alarm1_rise", alarm[1], 1'b1);
        sens_dir[1*c_W +: c_W] = 32'h0FF;
        @(posedge clk); #1;
        check_eq("alarm1_fall", alarm[1], 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        check_eq("alarm1_stays_low", alarm[1], 1'b0);
        check_eq("irq_set", irq, 1'b1);
        axi_read(1, rd);
        check_eq("status_sticky", rd, 32'h2);

        // Clear sticky
        axi_write(0, 32'hC000_0002, 4'hF, 0, 0, br);
        check_eq("irq_cleared", irq, 1'b0);
        axi_read(1, rd);
        check_eq("status_cleared", rd, 32'h0);
        axi_read(0, rd);
        check_eq("ctrl_clr_reads0", rd, 32'h8000_0002);

        // Set beats clear
        sens_dir[1*c_W +: c_W] = 32'h200;
        repeat (2) begin @(posedge clk); #1; end
        axi_write(0, 32'hC000_0002, 4'hF, 0, 0, br);
        axi_read(1, rd);
        check_eq("set_beats_clear", rd[1], 1'b1);

        // Write to STATUS
        axi_write(1, 32'h0000FFFF, 4'hF, 0, 0, br);
        check_eq("status_write_slverr", br, 2'b10);
        axi_read(1, rd);
        check_eq("status_unchanged", rd, 32'h2);

        // W three cycles ahead of AW, BREADY held off 4 cycles
        axi_write(6, 32'hDEAD_BEEF, 4'hF, 3, 4, br);
        axi_read(6, rd);
        check_eq("w_first_data", rd, 32'hDEAD_BEEF);

        // Reset while RVALID is high
        araddr  = c_AW'(7 * 4);
        arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        check_eq("rvalid_before_reset", rvalid, 1'b1);
        #2 rst = 1'b1;
        #1 check_eq("rvalid_drop_on_reset", rvalid, 1'b0);
        check_eq("irq_drop_on_reset", irq, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            axi_read(i, rd);
            check_eq($sformatf("post_reset_w%0d", i), rd, 32'h0);
        end

        // Randomized traffic
        sens_rand = 1'b1;
        for (int it = 0; it < 250; it++) begin
            r_idx = int'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 6) begin
                if (r_idx == 0)
                    r_data = $urandom;
                else if ($urandom_range(0, 2) != 0)
                    r_data = 32'($urandom_range(0, 600));
                else
                    r_data = $urandom;
                axi_write(r_idx, r_data, 4'($urandom_range(0, 15)),
                          int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 2)), br);
            end else begin
                axi_read(r_idx, rd);
            end
        end

        repeat (3) begin @(posedge clk); #1; end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global guard against a stuck run.
    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
